// File: rtl/cv32e40p_rf_ecc_pkg.sv
// Shared ECC definitions for the register-file scrubber: codeword geometry,
// Hamming parity positions, scrub FSM states and syndrome decode helper.
package cv32e40p_rf_ecc_pkg;

  localparam int unsigned CW_WIDTH  = 38;
  localparam int unsigned SYN_WIDTH = 6;

  // Parity bits sit at the power-of-two positions (1-based) of the codeword.
  localparam logic [SYN_WIDTH-1:0] PARITY_POS [SYN_WIDTH] =
    '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_WRITE
  } scrub_state_e;

  // Syndrome names the 1-based position of a single flipped bit; turn it
  // into a flip mask. Zero or out-of-range syndromes give an empty mask.
  function automatic logic [CW_WIDTH-1:0] syn_to_flip_mask(input logic [SYN_WIDTH-1:0] syn);
    logic [CW_WIDTH-1:0] mask;
    mask = '0;
    for (int p = 1; p <= CW_WIDTH; p++) begin
      if (syn == SYN_WIDTH'(p)) mask[p-1] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/cv32e40p_rf_ecc_corrector.sv
// Combinational Hamming SEC check of one 38-bit register-file codeword.
module cv32e40p_rf_ecc_corrector
  import cv32e40p_rf_ecc_pkg::*;
(
  input  logic [CW_WIDTH-1:0]  codeword,
  output logic [SYN_WIDTH-1:0] syndrome,
  output logic                 correctable,
  output logic                 uncorrectable,
  output logic [CW_WIDTH-1:0]  corrected
);

  // Syndrome bit k is the parity over every position whose index has bit k set.
  always_comb begin
    syndrome = '0;
    for (int k = 0; k < SYN_WIDTH; k++) begin
      for (int p = 1; p <= CW_WIDTH; p++) begin
        if ((SYN_WIDTH'(p) & PARITY_POS[k]) != '0) syndrome[k] = syndrome[k] ^ codeword[p-1];
      end
    end
  end

  assign correctable   = (syndrome != '0) && (syndrome <= SYN_WIDTH'(CW_WIDTH));
  assign uncorrectable = (syndrome > SYN_WIDTH'(CW_WIDTH));
  assign corrected     = codeword ^ syn_to_flip_mask(syndrome);

endmodule

// File: rtl/cv32e40p_register_file_scrubber.sv
// Background scrubber for the ECC-protected integer register file.
// Borrows read port C and write port B only when the core leaves them idle.
// Optional error-address logging: define CV32E40P_SCRUB_ERR_LOG_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | scrubbing disabled, pointer held
// S_WAIT  | interval down-counter running between two register visits
// S_READ  | waiting for a free port C cycle, codeword captured on grant
// S_CHECK | syndrome evaluated on the captured codeword
// S_WRITE | waiting for a free port B cycle to write the corrected word
module cv32e40p_register_file_scrubber #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned CW_WIDTH       = 38,
  parameter int unsigned SCRUB_INTERVAL = 64,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en_i,
  input  logic                  core_rc_busy_i,
  input  logic                  core_we_a_i,
  input  logic [ADDR_WIDTH-1:0] core_waddr_a_i,
  input  logic                  core_we_b_i,
  input  logic [ADDR_WIDTH-1:0] core_waddr_b_i,
  output logic                  scrub_rreq_o,
  output logic [ADDR_WIDTH-1:0] scrub_raddr_o,
  input  logic [CW_WIDTH-1:0]   scrub_rdata_i,
  output logic                  scrub_we_o,
  output logic [ADDR_WIDTH-1:0] scrub_waddr_o,
  output logic [CW_WIDTH-1:0]   scrub_wdata_o,
  output logic                  busy_o,
  output logic                  corr_pulse_o,
  output logic                  uncorr_pulse_o,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o
);
  import cv32e40p_rf_ecc_pkg::*;

  localparam int unsigned IV_WIDTH = $clog2(SCRUB_INTERVAL + 1);

  scrub_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [IV_WIDTH-1:0]   iv_cnt_q;
  logic [CW_WIDTH-1:0]   cw_q;
  logic                  abort_q;
  logic [CNT_WIDTH-1:0]  corr_cnt_q;

  logic                  grant, ptr_adv, iv_load;
  logic                  hit_a, hit_b;
  logic [SYN_WIDTH-1:0]  syndrome;
  logic                  correctable, uncorrectable;
  logic [CW_WIDTH-1:0]   corrected_cw;

  cv32e40p_rf_ecc_corrector u_corrector (
    .codeword      (cw_q),
    .syndrome      (syndrome),
    .correctable   (correctable),
    .uncorrectable (uncorrectable),
    .corrected     (corrected_cw)
  );

  assign hit_a = core_we_a_i && (core_waddr_a_i == ptr_q);
  assign hit_b = core_we_b_i && (core_waddr_b_i == ptr_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and port steering; dropping the enable wins over everything.
  always_comb begin
    state_d        = state_q;
    scrub_rreq_o   = 1'b0;
    scrub_raddr_o  = '0;
    scrub_we_o     = 1'b0;
    scrub_waddr_o  = '0;
    scrub_wdata_o  = '0;
    corr_pulse_o   = 1'b0;
    uncorr_pulse_o = 1'b0;
    grant          = 1'b0;
    ptr_adv        = 1'b0;
    iv_load        = 1'b0;
    if (!scrub_en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          iv_load = 1'b1;
        end
        S_WAIT: begin
          if (iv_cnt_q == '0) state_d = S_READ;
        end
        S_READ: begin
          if (!core_rc_busy_i) begin
            grant         = 1'b1;
            scrub_rreq_o  = 1'b1;
            scrub_raddr_o = ptr_q;
            state_d       = S_CHECK;
          end
        end
        S_CHECK: begin
          if (syndrome == '0) begin
            ptr_adv = 1'b1;
            iv_load = 1'b1;
            state_d = S_WAIT;
          end else if (correctable) begin
            state_d = S_WRITE;
          end else begin
            uncorr_pulse_o = uncorrectable;
            ptr_adv        = 1'b1;
            iv_load        = 1'b1;
            state_d        = S_WAIT;
          end
        end
        S_WRITE: begin
          if (abort_q) begin
            // Core wrote this register after we read it; its value is newer.
            ptr_adv = 1'b1;
            iv_load = 1'b1;
            state_d = S_WAIT;
          end else if (!core_we_b_i && !hit_a) begin
            scrub_we_o    = 1'b1;
            scrub_waddr_o = ptr_q;
            scrub_wdata_o = corrected_cw;
            corr_pulse_o  = 1'b1;
            ptr_adv       = 1'b1;
            iv_load       = 1'b1;
            state_d       = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pointer, interval timer, captured codeword, stale-data flag, correction count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= ADDR_WIDTH'(1);
      iv_cnt_q   <= '0;
      cw_q       <= '0;
      abort_q    <= 1'b0;
      corr_cnt_q <= '0;
    end else begin
      if (ptr_adv) begin
        ptr_q <= (ptr_q == ADDR_WIDTH'(NUM_REGS - 1)) ? ADDR_WIDTH'(1) : ptr_q + ADDR_WIDTH'(1);
      end
      if (iv_load) begin
        iv_cnt_q <= IV_WIDTH'(SCRUB_INTERVAL);
      end else if (state_q == S_WAIT && iv_cnt_q != '0) begin
        iv_cnt_q <= iv_cnt_q - IV_WIDTH'(1);
      end
      if (grant) begin
        cw_q    <= scrub_rdata_i;
        abort_q <= hit_a || hit_b;
      end else if (state_q == S_CHECK || state_q == S_WRITE) begin
        abort_q <= abort_q || hit_a || hit_b;
      end
      if (corr_pulse_o && corr_cnt_q != '1) begin
        corr_cnt_q <= corr_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign corr_cnt_o = corr_cnt_q;
  assign busy_o     = (state_q != S_IDLE) && (state_q != S_WAIT);

`ifdef CV32E40P_SCRUB_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic                  uncorr_sticky_q;

  // Log the address of each error until the first uncorrectable one freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_q      <= '0;
      uncorr_sticky_q <= 1'b0;
    end else if (!uncorr_sticky_q && (corr_pulse_o || uncorr_pulse_o)) begin
      err_addr_q <= ptr_q;
      if (uncorr_pulse_o) uncorr_sticky_q <= 1'b1;
    end
  end

  assign err_addr_o = err_addr_q;
`else
  assign err_addr_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_register_file_scrubber.sv
// Directed bench for the register-file scrubber with a behavioural register file.
module tb_cv32e40p_register_file_scrubber;

  localparam int AW   = 6;
  localparam int CW   = 38;
  localparam int CNTW = 2;
  localparam int IV   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            scrub_en_i, core_rc_busy_i, core_we_a_i, core_we_b_i;
  logic [AW-1:0]   core_waddr_a_i, core_waddr_b_i;
  logic            scrub_rreq_o, scrub_we_o, busy_o, corr_pulse_o, uncorr_pulse_o;
  logic [AW-1:0]   scrub_raddr_o, scrub_waddr_o, err_addr_o;
  logic [CW-1:0]   scrub_rdata_i, scrub_wdata_o;
  logic [CNTW-1:0] corr_cnt_o;

  logic [CW-1:0] mem [64];
  int tests_run = 0, tests_failed = 0, we_total = 0;

  always #5 clk = ~clk;
  assign scrub_rdata_i = mem[scrub_raddr_o];

  cv32e40p_register_file_scrubber #(
    .ADDR_WIDTH(AW), .NUM_REGS(32), .CW_WIDTH(CW), .SCRUB_INTERVAL(IV), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en_i(scrub_en_i), .core_rc_busy_i(core_rc_busy_i),
    .core_we_a_i(core_we_a_i), .core_waddr_a_i(core_waddr_a_i),
    .core_we_b_i(core_we_b_i), .core_waddr_b_i(core_waddr_b_i),
    .scrub_rreq_o(scrub_rreq_o), .scrub_raddr_o(scrub_raddr_o), .scrub_rdata_i(scrub_rdata_i),
    .scrub_we_o(scrub_we_o), .scrub_waddr_o(scrub_waddr_o), .scrub_wdata_o(scrub_wdata_o),
    .busy_o(busy_o), .corr_pulse_o(corr_pulse_o), .uncorr_pulse_o(uncorr_pulse_o),
    .corr_cnt_o(corr_cnt_o), .err_addr_o(err_addr_o)
  );

  // Independent Hamming encoder: data in non-power-of-two positions, parity fixes syndrome to 0.
  function automatic logic [CW-1:0] enc(input logic [31:0] d);
    logic [CW-1:0] cw;
    logic [5:0]    s;
    int            j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    s = '0;
    for (int p = 1; p <= CW; p++) if (cw[p-1]) s = s ^ 6'(p);
    for (int k = 0; k < 6; k++) if (s[k]) cw[(1 << k) - 1] = 1'b1;
    return cw;
  endfunction

  function automatic logic [31:0] dat(input int i);
    return 32'h1234_5678 ^ (32'(i) * 32'h0101_0101);
  endfunction

  task automatic next_cyc();
    @(negedge clk);
  endtask

  // Sample point of a cycle; also plays the register file's port B for scrub writes.
  task automatic settle();
    #1;
    if (scrub_we_o) begin
      mem[scrub_waddr_o] = scrub_wdata_o;
      we_total++;
    end
  endtask

  task automatic cyc();
    next_cyc();
    settle();
  endtask

  task automatic do_reset();
    rst = 1'b1; scrub_en_i = 1'b0; core_rc_busy_i = 1'b0;
    core_we_a_i = 1'b0; core_waddr_a_i = '0; core_we_b_i = 1'b0; core_waddr_b_i = '0;
    for (int i = 0; i < 64; i++) mem[i] = enc(dat(i));
    cyc();
    cyc();
    next_cyc();
    rst = 1'b0;
    settle();
  endtask

  task automatic wait_grant(output bit ok, output logic [AW-1:0] addr, output int cycles);
    ok = 1'b0; addr = '0; cycles = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      cycles++;
      if (scrub_rreq_o) begin
        ok   = 1'b1;
        addr = scrub_raddr_o;
        break;
      end
    end
  endtask

  task automatic goto_grant(input logic [AW-1:0] target);
    bit ok, g;
    logic [AW-1:0] a;
    int c;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      wait_grant(g, a, c);
      if (!g) break;
      if (a == target) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL goto_grant_%0d: grant seen=%0d, required 1", target, ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scrub_en_i = 1'b1; core_rc_busy_i = 1'b0;
    core_we_a_i = 1'b1; core_waddr_a_i = 6'd1; core_we_b_i = 1'b0; core_waddr_b_i = '0;
    for (int i = 0; i < 64; i++) mem[i] = enc(dat(i));
    cyc();
    cyc();
    tests_run++;
    if ({scrub_rreq_o, scrub_raddr_o, scrub_we_o, scrub_waddr_o, scrub_wdata_o, busy_o,
         corr_pulse_o, uncorr_pulse_o, corr_cnt_o, err_addr_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rreq=%b we=%b busy=%b cnt=%0d err=%0d, required all 0",
               scrub_rreq_o, scrub_we_o, busy_o, corr_cnt_o, err_addr_o);
    end
    next_cyc(); rst = 1'b0; scrub_en_i = 1'b0; core_we_a_i = 1'b0; settle();
    cyc();
    tests_run++;
    if (busy_o !== 1'b0 || scrub_rreq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_disabled: busy=%b rreq=%b, required 0 0", busy_o, scrub_rreq_o);
    end
  endtask

  task automatic test_clean_walk();
    bit g;
    logic [AW-1:0] a, exp_a;
    int c, we0;
    do_reset();
    we0 = we_total;
    scrub_en_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      exp_a = (k < 31) ? AW'(k + 1) : AW'(1);
      wait_grant(g, a, c);
      tests_run++;
      if (!g || a !== exp_a || c != ((k == 0) ? IV + 2 : IV + 3)) begin
        tests_failed++;
        $display("FAIL walk_%0d: grant=%0d addr=%0d gap=%0d, required 1 %0d %0d",
                 k, g, a, c, exp_a, (k == 0) ? IV + 2 : IV + 3);
      end
    end
    tests_run++;
    if (we_total != we0 || corr_cnt_o !== '0) begin
      tests_failed++;
      $display("FAIL walk_no_write: writes=%0d cnt=%0d, required 0 0", we_total - we0, corr_cnt_o);
    end
  endtask

  task automatic test_read_stall();
    bit seen;
    do_reset();
    scrub_en_i = 1'b1; core_rc_busy_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      seen |= scrub_rreq_o;
    end
    tests_run++;
    if (seen !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_stall: rreq seen=%b busy=%b, required 0 1", seen, busy_o);
    end
    next_cyc(); core_rc_busy_i = 1'b0; settle();
    tests_run++;
    if (scrub_rreq_o !== 1'b1 || scrub_raddr_o !== 6'd1) begin
      tests_failed++;
      $display("FAIL read_release: rreq=%b addr=%0d, required 1 1", scrub_rreq_o, scrub_raddr_o);
    end
  endtask

  task automatic test_single_correct();
    do_reset();
    mem[7][5] = ~mem[7][5];
    scrub_en_i = 1'b1;
    goto_grant(6'd7);
    cyc();
    tests_run++;
    if (busy_o !== 1'b1 || scrub_we_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL corr_check_cycle: busy=%b we=%b, required 1 0", busy_o, scrub_we_o);
    end
    cyc();
    tests_run++;
    if (scrub_we_o !== 1'b1 || scrub_waddr_o !== 6'd7 || scrub_wdata_o !== enc(dat(7)) || corr_pulse_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL corr_write: we=%b addr=%0d data=%h pulse=%b, required 1 7 %h 1",
               scrub_we_o, scrub_waddr_o, scrub_wdata_o, corr_pulse_o, enc(dat(7)));
    end
    cyc();
    tests_run++;
    if (corr_cnt_o !== 2'd1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL corr_count: cnt=%0d busy=%b, required 1 0", corr_cnt_o, busy_o);
    end
  endtask

  task automatic test_write_stall();
    bit seen;
    do_reset();
    mem[9][20] = ~mem[9][20];
    scrub_en_i = 1'b1;
    goto_grant(6'd9);
    cyc();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cyc(); core_we_b_i = 1'b1; core_waddr_b_i = 6'd20; settle();
      seen |= scrub_we_o;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_stall: we seen=%b, required 0", seen);
    end
    next_cyc(); core_we_b_i = 1'b0; settle();
    tests_run++;
    if (scrub_we_o !== 1'b1 || scrub_waddr_o !== 6'd9 || scrub_wdata_o !== enc(dat(9))) begin
      tests_failed++;
      $display("FAIL write_after_stall: we=%b addr=%0d data=%h, required 1 9 %h",
               scrub_we_o, scrub_waddr_o, scrub_wdata_o, enc(dat(9)));
    end
  endtask

  task automatic test_abort_port_a();
    bit g, seen;
    logic [AW-1:0] a;
    int c, we0;
    do_reset();
    mem[12][0] = ~mem[12][0];
    scrub_en_i = 1'b1;
    goto_grant(6'd12);
    we0 = we_total;
    next_cyc(); core_we_a_i = 1'b1; core_waddr_a_i = 6'd12; settle();
    next_cyc(); core_we_a_i = 1'b0; settle();
    seen = scrub_we_o;
    wait_grant(g, a, c);
    tests_run++;
    if (seen !== 1'b0 || we_total != we0 || corr_cnt_o !== '0) begin
      tests_failed++;
      $display("FAIL abort_drop: we=%b writes=%0d cnt=%0d, required 0 0 0", seen, we_total - we0, corr_cnt_o);
    end
    tests_run++;
    if (!g || a !== 6'd13) begin
      tests_failed++;
      $display("FAIL abort_ptr: grant=%0d addr=%0d, required 1 13", g, a);
    end
  endtask

  task automatic test_uncorrectable();
    bit g;
    logic [AW-1:0] a, exp_err;
    int c, we0;
    do_reset();
    mem[3][0]  = ~mem[3][0];
    mem[3][7]  = ~mem[3][7];
    mem[3][31] = ~mem[3][31];
    mem[5][2]  = ~mem[5][2];
`ifdef CV32E40P_SCRUB_ERR_LOG_EN
    exp_err = 6'd3;
`else
    exp_err = 6'd0;
`endif
    scrub_en_i = 1'b1;
    goto_grant(6'd3);
    we0 = we_total;
    cyc();
    tests_run++;
    if (uncorr_pulse_o !== 1'b1 || scrub_we_o !== 1'b0 || corr_pulse_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL uncorr_pulse: uncorr=%b we=%b corr=%b, required 1 0 0", uncorr_pulse_o, scrub_we_o, corr_pulse_o);
    end
    cyc();
    tests_run++;
    if (err_addr_o !== exp_err) begin
      tests_failed++;
      $display("FAIL uncorr_err_addr: err_addr=%0d, required %0d", err_addr_o, exp_err);
    end
    wait_grant(g, a, c);
    tests_run++;
    if (!g || a !== 6'd4 || we_total != we0 || corr_cnt_o !== '0) begin
      tests_failed++;
      $display("FAIL uncorr_no_write: addr=%0d writes=%0d cnt=%0d, required 4 0 0", a, we_total - we0, corr_cnt_o);
    end
    goto_grant(6'd5);
    cyc();
    cyc();
    cyc();
    tests_run++;
    if (corr_cnt_o !== 2'd1 || err_addr_o !== exp_err) begin
      tests_failed++;
      $display("FAIL sticky_err_addr: cnt=%0d err_addr=%0d, required 1 %0d", corr_cnt_o, err_addr_o, exp_err);
    end
  endtask

  task automatic test_rst_in_write();
    bit g;
    logic [AW-1:0] a;
    int c, we0;
    do_reset();
    mem[5][10] = ~mem[5][10];
    scrub_en_i = 1'b1;
    goto_grant(6'd5);
    we0 = we_total;
    cyc();
    next_cyc(); core_we_b_i = 1'b1; core_waddr_b_i = 6'd0; settle();
    next_cyc(); core_we_b_i = 1'b0; rst = 1'b1; settle();
    tests_run++;
    if (scrub_we_o !== 1'b0 || busy_o !== 1'b0 || corr_cnt_o !== '0) begin
      tests_failed++;
      $display("FAIL rst_in_write: we=%b busy=%b cnt=%0d, required 0 0 0", scrub_we_o, busy_o, corr_cnt_o);
    end
    next_cyc(); rst = 1'b0; settle();
    wait_grant(g, a, c);
    tests_run++;
    if (!g || a !== 6'd1 || we_total != we0) begin
      tests_failed++;
      $display("FAIL rst_restart: addr=%0d writes=%0d, required 1 0", a, we_total - we0);
    end
  endtask

  task automatic test_en_drop_in_write();
    bit g;
    logic [AW-1:0] a;
    int c;
    do_reset();
    mem[5][33] = ~mem[5][33];
    scrub_en_i = 1'b1;
    goto_grant(6'd5);
    cyc();
    next_cyc(); scrub_en_i = 1'b0; settle();
    tests_run++;
    if (scrub_we_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_drop_write: we=%b, required 0", scrub_we_o);
    end
    cyc();
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_drop_idle: busy=%b, required 0", busy_o);
    end
    next_cyc(); scrub_en_i = 1'b1; settle();
    wait_grant(g, a, c);
    tests_run++;
    if (!g || a !== 6'd5) begin
      tests_failed++;
      $display("FAIL en_resume_ptr: grant=%0d addr=%0d, required 1 5", g, a);
    end
    cyc();
    cyc();
    tests_run++;
    if (scrub_we_o !== 1'b1 || scrub_waddr_o !== 6'd5 || scrub_wdata_o !== enc(dat(5))) begin
      tests_failed++;
      $display("FAIL en_resume_write: we=%b addr=%0d data=%h, required 1 5 %h",
               scrub_we_o, scrub_waddr_o, scrub_wdata_o, enc(dat(5)));
    end
  endtask

  task automatic test_saturation();
    int pulses;
    do_reset();
    for (int r = 1; r <= 4; r++) mem[r][r + 8] = ~mem[r][r + 8];
    scrub_en_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      cyc();
      if (corr_pulse_o) pulses++;
    end
    tests_run++;
    if (pulses != 4 || corr_cnt_o !== 2'd3) begin
      tests_failed++;
      $display("FAIL cnt_saturate: pulses=%0d cnt=%0d, required 4 3", pulses, corr_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_clean_walk();
    test_read_stall();
    test_single_correct();
    test_write_stall();
    test_abort_port_a();
    test_uncorrectable();
    test_rst_in_write();
    test_en_drop_in_write();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
